// File: rtl/dm_port_arbiter_if.sv
// Requester-side handshake bundle for one data-memory port.
// The arbiter takes the slave modport; loaders and the CPU stage take master.
interface dm_port_arbiter_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [31:0] pc;
  logic        ack;
  logic        err;
  logic [31:0] rd;

  modport master (output req, we, addr, wd, pc, input ack, err, rd);
  modport slave  (input req, we, addr, wd, pc, output ack, err, rd);
endinterface

// File: rtl/dm_port_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of the single-port data memory.
// Define DM_ARB_TRACE_EN to print committed stores and rejected accesses.
module dm_port_arbiter #(
  parameter int unsigned DM_WORDS   = 1024,
  parameter int unsigned RESET_PRIO = 0
) (
  input  logic        Clock,
  input  logic        Reset,
  dm_port_arbiter_if.slave p0,
  dm_port_arbiter_if.slave p1,
  output logic        mem_we,
  output logic        mem_re,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic [31:0] mem_pc,
  input  logic [31:0] mem_rd,
  output logic        busy,
  output logic        grant_id
);

  localparam logic [32:0] AddrLimit = 33'(DM_WORDS) << 2;
  localparam logic        PrioInit  = 1'(RESET_PRIO);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e      state_q, state_d;
  logic        gnt_q, gnt_d, prio_q, prio_d;
  logic        lat_we_q, lat_we_d, lat_err_q, lat_err_d;
  logic [31:0] lat_addr_q, lat_addr_d, lat_wd_q, lat_wd_d, lat_pc_q, lat_pc_d;
  logic        ack0_q, ack0_d, ack1_q, ack1_d, err0_q, err0_d, err1_q, err1_d;
  logic [31:0] rd0_q, rd0_d, rd1_q, rd1_d;

  logic        r0, r1, sel, sel_we;
  logic [31:0] sel_addr, sel_wd, sel_pc, load_data;

  // The port just served in RESP is masked so the other one gets the next slot.
  always_comb begin
    r0 = p0.req & ((state_q == StIdle) | ((state_q == StResp) & gnt_q));
    r1 = p1.req & ((state_q == StIdle) | ((state_q == StResp) & ~gnt_q));
    sel      = (r0 & r1) ? prio_q : r1;
    sel_we   = sel ? p1.we   : p0.we;
    sel_addr = sel ? p1.addr : p0.addr;
    sel_wd   = sel ? p1.wd   : p0.wd;
    sel_pc   = sel ? p1.pc   : p0.pc;
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    prio_d     = prio_q;
    lat_we_d   = lat_we_q;
    lat_err_d  = lat_err_q;
    lat_addr_d = lat_addr_q;
    lat_wd_d   = lat_wd_q;
    lat_pc_d   = lat_pc_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    err0_d     = 1'b0;
    err1_d     = 1'b0;
    rd0_d      = rd0_q;
    rd1_d      = rd1_q;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_addr   = '0;
    mem_wd     = '0;
    mem_pc     = '0;
    load_data  = (~lat_we_q & ~lat_err_q) ? mem_rd : 32'h0;
    unique case (state_q)
      StIdle, StResp: begin
        if (r0 | r1) begin
          state_d    = StAccess;
          gnt_d      = sel;
          lat_we_d   = sel_we;
          lat_addr_d = sel_addr;
          lat_wd_d   = sel_wd;
          lat_pc_d   = sel_pc;
          lat_err_d  = (sel_addr[1:0] != 2'b00) | ({1'b0, sel_addr} >= AddrLimit);
        end else begin
          state_d = StIdle;
        end
      end
      StAccess: begin
        // Strobes are gated by Reset so a reset edge never commits a write.
        mem_we   = lat_we_q & ~lat_err_q & ~Reset;
        mem_re   = ~lat_we_q & ~lat_err_q & ~Reset;
        mem_addr = lat_addr_q;
        mem_wd   = lat_wd_q;
        mem_pc   = lat_pc_q;
        if (gnt_q) begin
          ack1_d = 1'b1;
          err1_d = lat_err_q;
          rd1_d  = load_data;
        end else begin
          ack0_d = 1'b1;
          err0_d = lat_err_q;
          rd0_d  = load_data;
        end
        prio_d  = ~gnt_q;
        state_d = StResp;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= StIdle;
      gnt_q      <= 1'b0;
      prio_q     <= PrioInit;
      lat_we_q   <= 1'b0;
      lat_err_q  <= 1'b0;
      lat_addr_q <= '0;
      lat_wd_q   <= '0;
      lat_pc_q   <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      err0_q     <= 1'b0;
      err1_q     <= 1'b0;
      rd0_q      <= '0;
      rd1_q      <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      prio_q     <= prio_d;
      lat_we_q   <= lat_we_d;
      lat_err_q  <= lat_err_d;
      lat_addr_q <= lat_addr_d;
      lat_wd_q   <= lat_wd_d;
      lat_pc_q   <= lat_pc_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      err0_q     <= err0_d;
      err1_q     <= err1_d;
      rd0_q      <= rd0_d;
      rd1_q      <= rd1_d;
    end
  end

  assign p0.ack   = ack0_q;
  assign p0.err   = err0_q;
  assign p0.rd    = rd0_q;
  assign p1.ack   = ack1_q;
  assign p1.err   = err1_q;
  assign p1.rd    = rd1_q;
  assign busy     = (state_q != StIdle);
  assign grant_id = gnt_q;

`ifdef DM_ARB_TRACE_EN
  always @(posedge Clock) begin
    if (!Reset && state_q == StAccess) begin
      if (lat_we_q && !lat_err_q) begin
        $display("@%08h: *%08h <= %08h", lat_pc_q, lat_addr_q, lat_wd_q);
      end
      if (lat_err_q) begin
        $display("ERR port%0d @%08h addr %08h", gnt_q, lat_pc_q, lat_addr_q);
      end
    end
  end
`else
`endif

endmodule
